// File: rtl/shift_acc_pkg.sv
// Shared types for the shift/accumulate stage.
//   op_t      : operation code carried with each transaction
//   result_t  : {ovf, data} word stored in the output FIFO
//   SHAMT_W   : number of low operand-b bits used as shift amount
package shift_acc_pkg;

    localparam int SHAMT_W = 4;
    localparam int DATA_W  = 9;

    typedef enum logic [1:0] {
        OP_SHL  = 2'b00,
        OP_SHR  = 2'b01,
        OP_ASHR = 2'b10,
        OP_ACC  = 2'b11
    } op_t;

    typedef struct packed {
        logic              ovf;
        logic [DATA_W-1:0] data;
    } result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
//   push/wdata : write an element (push while full is only allowed with pop)
//   pop        : remove the head element; ignored when empty
//   rdata      : current head element (stale when empty)
//   count      : occupancy, 0..DEPTH
//   empty/full : occupancy flags
module sync_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_ONE << PW);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // A full FIFO may still take a write on the edge that frees the head.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && empty));

endmodule

// File: rtl/shift_acc_stage.sv
// Shift / accumulate datapath stage.
//   in_valid/in_ready, in_op, in_a, in_b : operand transaction (b[3:0] = shift)
//   out_valid/out_ready, out_data, out_ovf : result at the FIFO head
//   acc : running accumulator, updated only when an ACC result is pushed
// One input register stage feeds a DEPTH-entry FIFO. in_ready only grants
// a transaction when the FIFO plus stage 1 still have a free slot, so
// stage 1 can always push without checking FIFO space.
module shift_acc_stage
    import shift_acc_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int PW    = $clog2(DEPTH);
    localparam int SHL_W = WIDTH + (1 << SHAMT_W) - 1;

    logic               s1_valid_q, s1_valid_d;
    op_t                s1_op_q, s1_op_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [SHAMT_W-1:0] s1_b_q, s1_b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               rdy_en_q, rdy_en_d;
    result_t            head_q, head_d;

    result_t            res;
    result_t            fifo_rdata;
    logic [PW:0]        fifo_count;
    logic               fifo_empty, fifo_full;
    logic               accept, pop;
    logic [PW+1:0]      pending;
    logic [SHL_W-1:0]   shl_wide;
    logic [WIDTH:0]     sum;
    logic               unused_b;

    assign unused_b = ^in_b[WIDTH-1:SHAMT_W];

    // rdy_en_q keeps in_ready low until the first edge after reset drops.
    assign pending  = (PW+2)'(fifo_count) + (PW+2)'(s1_valid_q);
    assign in_ready = !reset && rdy_en_q && (pending < (PW+2)'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop      = out_valid && out_ready;
    assign acc      = acc_q;

    // Empty FIFO: present the last popped result instead of stale storage.
    assign out_data = fifo_empty ? head_q.data : fifo_rdata.data;
    assign out_ovf  = fifo_empty ? head_q.ovf  : fifo_rdata.ovf;

    always_comb begin
        s1_valid_d = accept;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_op_d = op_t'(in_op);
            s1_a_d  = in_a;
            s1_b_d  = in_b[SHAMT_W-1:0];
        end
        rdy_en_d = 1'b1;
        head_d   = pop ? fifo_rdata : head_q;
    end

    // Result of the stage-1 transaction; pushed on the next edge.
    always_comb begin
        // Widened shift keeps every bit that falls off the top for ovf.
        shl_wide = {{(SHL_W-WIDTH){1'b0}}, s1_a_q} << s1_b_q;
        sum      = {1'b0, acc_q} + {1'b0, s1_a_q};
        res      = '0;
        acc_d    = acc_q;
        case (s1_op_q)
            OP_SHL: begin
                res.data = shl_wide[WIDTH-1:0];
                res.ovf  = |shl_wide[SHL_W-1:WIDTH];
            end
            OP_SHR:  res.data = s1_a_q >> s1_b_q;
            OP_ASHR: res.data = $unsigned($signed(s1_a_q) >>> s1_b_q);
            OP_ACC: begin
                res.data = sum[WIDTH-1:0];
                res.ovf  = sum[WIDTH];
                if (s1_valid_q) acc_d = sum[WIDTH-1:0];
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_SHL;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            acc_q      <= '0;
            rdy_en_q   <= 1'b0;
            head_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            acc_q      <= acc_d;
            rdy_en_q   <= rdy_en_d;
            head_q     <= head_d;
        end
    end

    sync_fifo #(
        .W     ($bits(result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_valid_q),
        .pop   (pop),
        .wdata (res),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    a_s1_never_blocked: assert property (@(posedge clk) disable iff (reset)
        !(s1_valid_q && fifo_full && !pop));

endmodule

// File: tb/tb_shift_acc_stage.sv
module tb_shift_acc_stage;

    localparam int W = 9;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready, out_valid, out_ovf;
    logic [W-1:0] out_data, acc;

    shift_acc_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: results in arrival order; acc as seen architecturally.
    typedef struct {int data; int ovf;} res_s;
    res_s fq[$];        // results already pushed, oldest first
    bit   s1v;          // a result still one edge from being visible
    res_s s1r;
    int   s1acc;
    int   m_acc;        // visible accumulator
    int   m_acc_next;   // accumulator after every accepted transaction
    bit   rdy_en;
    int   last_d, last_o;
    int   got_d[$], got_o[$];
    int   n_acc;

    function automatic void ref_op(input int op, input int a, input int b, input int acc_in,
                                   output int d, output int o, output int acc_out);
        int sh, full, sa, q, s;
        sh = b % 16;
        acc_out = acc_in;
        o = 0;
        d = 0;
        case (op)
            0: begin full = a * (1 << sh); d = full % 512; o = int'(full >= 512); end
            1: d = a / (1 << sh);
            2: begin
                sa = (a >= 256) ? a - 512 : a;
                if (sa >= 0) q = sa / (1 << sh);
                else         q = -((-sa + (1 << sh) - 1) / (1 << sh));
                d = q & 511;
            end
            default: begin s = acc_in + a; d = s % 512; o = int'(s >= 512); acc_out = d; end
        endcase
    endfunction

    task automatic cyc(input bit iv, input int op, input int a, input int b, input bit ordy);
        bit er, acc_ev, pop_ev;
        int d, o, na;
        in_valid = iv; in_op = op[1:0]; in_a = a[W-1:0]; in_b = b[W-1:0]; out_ready = ordy;
        #1;
        er = rdy_en && (fq.size() + int'(s1v) < D);
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, fq.size() > 0);
        if (fq.size() > 0) begin
            chk("out_data", out_data, fq[0].data);
            chk("out_ovf", out_ovf, fq[0].ovf);
        end else begin
            chk("hold_data", out_data, last_d);
            chk("hold_ovf", out_ovf, last_o);
        end
        chk("acc", acc, m_acc);
        acc_ev = iv && er;
        pop_ev = (fq.size() > 0) && ordy;
        @(posedge clk);
        if (pop_ev) begin
            last_d = fq[0].data; last_o = fq[0].ovf;
            got_d.push_back(last_d); got_o.push_back(last_o);
            void'(fq.pop_front());
        end
        if (s1v) begin fq.push_back(s1r); m_acc = s1acc; end
        s1v = acc_ev;
        if (acc_ev) begin
            ref_op(op, a, b, m_acc_next, d, o, na);
            s1r = '{d, o}; s1acc = na; m_acc_next = na; n_acc++;
        end
        rdy_en = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        fq.delete(); s1v = 0; m_acc = 0; m_acc_next = 0; rdy_en = 0; last_d = 0; last_o = 0;
        @(posedge clk); #1;
        chk("rst_hold_valid", out_valid, 0);
        @(negedge clk); reset = 1'b0; #1;
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(0, 0, 0, 0, 1);
    endtask

    int   exp_d [8] = '{'h1FE, 'h1FC, 'h1F0, 'h030, 'h1FF, 'h100, 'h000, 'h005};
    int   exp_o [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
    int   dir_op[8] = '{0, 0, 2, 1, 2, 3, 3, 3};
    int   dir_a [8] = '{'h0FF, 'h0FF, 'h180, 'h180, 'h180, 'h100, 'h100, 'h005};
    int   dir_b [8] = '{1, 2, 3, 3, 15, 0, 0, 0};
    res_s snap[$];

    initial begin
        do_reset();
        cyc(0, 0, 0, 0, 1);   // in_ready still low on the first cycle
        cyc(0, 0, 0, 0, 1);

        // Directed operations from the plan
        got_d.delete(); got_o.delete(); n_acc = 0;
        for (int i = 0; i < 8; i++) cyc(1, dir_op[i], dir_a[i], dir_b[i], 1);
        drain(4);
        chk("dir_accepts", n_acc, 8);
        chk("dir_count", got_d.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_d.size()) begin
                chk($sformatf("dir_data%0d", i), got_d[i], exp_d[i]);
                chk($sformatf("dir_ovf%0d", i), got_o[i], exp_o[i]);
            end
        end
        chk("dir_acc_end", acc, 'h005);

        // Backpressure: only DEPTH transactions may be taken
        n_acc = 0;
        repeat (10) cyc(1, $urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 511), 0);
        chk("bp_accepts", n_acc, 4);
        chk("bp_in_ready_low", in_ready, 0);
        snap = fq;
        got_d.delete(); got_o.delete();
        drain(6);
        chk("bp_drain_count", got_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size() && i < snap.size())
                chk($sformatf("bp_order%0d", i), got_d[i], snap[i].data);
        end

        // Start full, then pop and offer every cycle
        repeat (6) cyc(1, $urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 511), 0);
        repeat (20) cyc(1, $urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 511), 1);
        drain(6);

        // Random traffic
        repeat (300) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 511),
                         $urandom_range(0, 511), $urandom_range(0, 2) != 0);
        drain(8);

        // Reset with three results queued and acc = 0x22
        do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(1, 3, 'h22, 0, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 2, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("pre_rst_acc", acc, 'h22);
        chk("pre_rst_queued", out_valid, 1);
        do_reset();
        cyc(0, 0, 0, 0, 1);
        got_d.delete(); got_o.delete();
        cyc(1, 3, 1, 0, 1);
        drain(3);
        chk("post_rst_count", got_d.size(), 1);
        if (got_d.size() > 0) chk("post_rst_data", got_d[0], 'h001);
        chk("post_rst_acc", acc, 'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
